fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the program-counter register: computes pc_next each cycle and drives the instruction-memory request/response handshake.
- Hands fetched instructions to decode over a valid/ready interface.
- Sits between the PC register (pc_next -> its pc_in; its pc_out -> pc_cur), instruction memory, decode, and the branch/trap logic.
- Single outstanding fetch, one-entry instruction buffer.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, target on trap_valid or on a misaligned-redirect fault.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- pc_cur  in  32  current PC from the PC register.
- pc_next  out  32  next PC to the PC register, latched every clk.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  32  fetch address, always equals pc_cur.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response strobe, one cycle.
- imem_rsp_data  in  32  fetched word.
- instr_valid  out  1  instruction available to decode.
- instr_data  out  32  buffered instruction.
- instr_pc  out  32  address of instr_data.
- instr_ready  in  1  decode accepts; low means stall.
- redirect_valid  in  1  taken branch or jump.
- redirect_target  in  32  branch/jump target.
- trap_valid  in  1  trap request.
- misalign_fault  out  1  one-cycle pulse, redirect target not word aligned.

Behaviour:
- States: RESET, REQ, RESP, DELIVER. 2-bit encoding; the state enum lives in the package.
- rst low (any time, asynchronous):
  - state=RESET, drop flag=0.
  - instr_valid=0, instr_data=0, instr_pc=0, imem_req_valid=0, misalign_fault=0.
  - pc_next=RESET_VECTOR.
- RESET: lasts one cycle after rst deasserts; pc_next=RESET_VECTOR; then REQ. The first request therefore presents RESET_VECTOR.
- REQ:
  - imem_req_valid=1, addr=pc_cur, pc_next=pc_cur.
  - On imem_req_ready -> RESP.
- RESP:
  - Wait for imem_rsp_valid; pc_next=pc_cur.
  - On response with drop=0: buffer data, set instr_pc=pc_cur, go to DELIVER.
  - On response with drop=1: discard the data, clear drop, go to REQ.
- DELIVER:
  - instr_valid=1.
  - On instr_valid && instr_ready: pc_next=pc_cur+4 (mod 2^32, wraps to 0), then REQ the next cycle.
  - Otherwise hold: pc_next=pc_cur, data stable.
- Fetch-to-instr_valid latency is one cycle after imem_rsp_valid. Throughput is at most one instruction per 3 cycles with zero-wait memory.
- Next-PC priority: trap_valid > redirect_valid > handshake advance > hold.
  - trap: pc_next=TRAP_VECTOR.
  - redirect: pc_next=redirect_target.
- A trap or redirect takes effect in any non-RESET state, the same cycle:
  - REQ with ready=0: request withdrawn; REQ next cycle on the new pc_cur.
  - REQ with ready=1, or RESP: drop=1. The pending response is discarded and the state moves to or stays in RESP.
  - RESP with imem_rsp_valid the same cycle: response discarded, go to REQ.
  - DELIVER: instr_valid clears next cycle, go to REQ. If the handshake fires the same cycle, the instruction counts as consumed and the redirect still wins pc_next.
- The drop flag is cleared only by a discarded response or by reset.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - redirect_target[1:0]!=0 pulses misalign_fault for one cycle and sets pc_next=TRAP_VECTOR instead of the target.
  - trap_valid in the same cycle still yields TRAP_VECTOR, with no fault pulse.
- Undefined: misalign_fault tied 0; pc_next={redirect_target[31:2],2'b00}.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e enum.
  - PC_INC=32'd4.
  - default RESET_VECTOR/TRAP_VECTOR constants.
- Sub-module next_pc_mux: combinational priority select of trap/redirect/advance/hold, including misalignment detection. Everything else stays in fetch_sequencer.

Test Plan:
- Reset then zero-wait memory returning 0x13, instr_ready=1 -> imem_req_addr 0x0, 0x4, 0x8; instr_valid one cycle after each rsp; instr_pc matches each address.
- instr_ready=0 for 5 cycles in DELIVER -> instr_data and instr_pc stable, pc_next=pc_cur, no new request; release -> pc_next=pc_cur+4.
- redirect_valid to 0x200 during RESP -> next response discarded, no instr_valid; next request addr=0x200.
- trap_valid and redirect_valid (0x300) in the same cycle -> pc_next=0x100; redirect ignored.
- pc_cur=0xFFFF_FFFC delivered -> pc_next=0x0000_0000.
- redirect_target=0x202 with MISALIGN_TRAP_EN -> misalign_fault pulse, next fetch at 0x100; without it -> next fetch at 0x200, fault stays 0. rst asserted mid-RESP -> outputs zero immediately, first fetch at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the fetch sequencer.
//
// Contents:
//   fetch_state_e     2-bit sequencer state (RESET, REQ, RESP, DELIVER)
//   PC_INC            sequential PC increment (one 32-bit word)
//   DEF_RESET_VECTOR  default first fetch address after reset
//   DEF_TRAP_VECTOR   default trap / misalignment-fault target
//   is_misaligned()   true when an address is not word aligned
//
// Optional feature macro used by files importing this package:
//   MISALIGN_TRAP_EN

package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_REQ     = 2'd1,
    ST_RESP    = 2'd2,
    ST_DELIVER = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// next_pc_mux -- combinational next-PC priority select.
//
// Priority: trap > redirect > sequential advance > hold.
//
// Ports:
//   trap_valid       in   trap request (already qualified by the caller)
//   redirect_valid   in   taken branch / jump (already qualified)
//   redirect_target  in   branch / jump target
//   advance          in   decode handshake fired, step to pc_cur + 4
//   pc_cur           in   current PC
//   pc_next          out  selected next PC
//   misalign         out  redirect target was not word aligned and was
//                         replaced by TRAP_VECTOR (only with MISALIGN_TRAP_EN)
//
// Build option:
//   MISALIGN_TRAP_EN  defined   -> misaligned redirect traps to TRAP_VECTOR
//                     undefined -> target low two bits are forced to zero

module next_pc_mux
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic        trap_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        advance,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        misalign
);

  always_comb begin
    pc_next  = pc_cur;
    misalign = 1'b0;
    if (trap_valid) begin
      // A coincident misaligned redirect is shadowed by the trap: no fault.
      pc_next = TRAP_VECTOR;
    end else if (redirect_valid) begin
`ifdef MISALIGN_TRAP_EN
      if (is_misaligned(redirect_target)) begin
        misalign = 1'b1;
        pc_next  = TRAP_VECTOR;
      end else begin
        pc_next = redirect_target;
      end
`else
      pc_next = redirect_target & ~32'h0000_0003;
`endif
    end else if (advance) begin
      // Plain 32-bit add: 0xFFFF_FFFC wraps to 0x0000_0000.
      pc_next = pc_cur + PC_INC;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- program-counter sequencing and instruction fetch.
//
// Computes pc_next for the external PC register, issues one instruction
// memory request at a time, buffers the returned word in a single entry
// and hands it to decode.
//
// Ports:
//   clk              in   system clock
//   rst              in   asynchronous active-low reset
//   pc_cur           in   current PC (PC register output)
//   pc_next          out  next PC (PC register input, latched every clk)
//   imem_req_valid   out  fetch request
//   imem_req_addr    out  fetch address, always pc_cur
//   imem_req_ready   in   memory accepts the request
//   imem_rsp_valid   in   one-cycle response strobe
//   imem_rsp_data    in   fetched word
//   instr_valid      out  instruction available to decode
//   instr_data       out  buffered instruction
//   instr_pc         out  address of instr_data
//   instr_ready      in   decode accepts (low = stall)
//   redirect_valid   in   taken branch / jump
//   redirect_target  in   branch / jump target
//   trap_valid       in   trap request
//   misalign_fault   out  one-cycle pulse, registered: asserted the cycle
//                         after a misaligned redirect was replaced by the
//                         trap vector
//   dbg_state        out  current sequencer state
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. Request valid/addr are held until ready or until a trap or
// redirect withdraws the request; instr_valid/data/pc are held stable until
// instr_ready or a trap/redirect. The memory returns exactly one
// imem_rsp_valid pulse per accepted request, at least one cycle later.
//
// Build option: MISALIGN_TRAP_EN (see next_pc_mux). When undefined,
// misalign_fault is tied to 0.

module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_cur,
  output logic [31:0]  pc_next,
  output logic         imem_req_valid,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_req_ready,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  output logic         instr_valid,
  output logic [31:0]  instr_data,
  output logic [31:0]  instr_pc,
  input  logic         instr_ready,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_target,
  input  logic         trap_valid,
  output logic         misalign_fault,
  output fetch_state_e dbg_state
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;
  logic         imem_req_valid_q, imem_req_valid_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_data_q, instr_data_d;
  logic [31:0]  instr_pc_q, instr_pc_d;

  logic         active;
  logic         trap_q_in;
  logic         redirect_q_in;
  logic         flush;
  logic         advance;
  logic [31:0]  mux_pc_next;
  logic         mux_misalign;

  // Traps and redirects are ignored during the single RESET cycle.
  assign active        = (state_q != ST_RESET);
  assign trap_q_in     = active & trap_valid;
  assign redirect_q_in = active & redirect_valid;
  assign flush         = trap_q_in | redirect_q_in;
  assign advance       = (state_q == ST_DELIVER) & instr_valid_q & instr_ready;

  next_pc_mux #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_pc_mux (
    .trap_valid      (trap_q_in),
    .redirect_valid  (redirect_q_in),
    .redirect_target (redirect_target),
    .advance         (advance),
    .pc_cur          (pc_cur),
    .pc_next         (mux_pc_next),
    .misalign        (mux_misalign)
  );

  // RESET forces the reset vector so the first request presents it.
  assign pc_next       = (state_q == ST_RESET) ? RESET_VECTOR : mux_pc_next;
  assign imem_req_addr = pc_cur;

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    instr_data_d = instr_data_q;
    instr_pc_d   = instr_pc_q;
    unique case (state_q)
      ST_RESET: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        // Without ready a flush simply withdraws the request: staying in
        // REQ re-issues it on the new pc_cur next cycle.
        if (imem_req_ready) begin
          state_d = ST_RESP;
          if (flush) drop_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (imem_rsp_valid) begin
          if (drop_q || flush) begin
            // Stale response: discard it and refetch from the new PC.
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            instr_data_d = imem_rsp_data;
            instr_pc_d   = pc_cur;
            state_d      = ST_DELIVER;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      ST_DELIVER: begin
        // A handshake coinciding with a flush still consumes the
        // instruction; the mux gives the flush priority on pc_next.
        if (flush || advance) state_d = ST_REQ;
      end
      default: state_d = ST_RESET;
    endcase
    imem_req_valid_d = (state_d == ST_REQ);
    instr_valid_d    = (state_d == ST_DELIVER);
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_fault_q, misalign_fault_d;
  assign misalign_fault_d = mux_misalign;
  assign misalign_fault   = misalign_fault_q;
`else
  logic unused_misalign;
  assign unused_misalign = mux_misalign;
  assign misalign_fault  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_RESET;
      drop_q           <= 1'b0;
      imem_req_valid_q <= 1'b0;
      instr_valid_q    <= 1'b0;
      instr_data_q     <= 32'h0;
      instr_pc_q       <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      misalign_fault_q <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      drop_q           <= drop_d;
      imem_req_valid_q <= imem_req_valid_d;
      instr_valid_q    <= instr_valid_d;
      instr_data_q     <= instr_data_d;
      instr_pc_q       <= instr_pc_d;
`ifdef MISALIGN_TRAP_EN
      misalign_fault_q <= misalign_fault_d;
`endif
    end
  end

  assign imem_req_valid = imem_req_valid_q;
  assign instr_valid    = instr_valid_q;
  assign instr_data     = instr_data_q;
  assign instr_pc       = instr_pc_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer -- directed self-checking bench for fetch_sequencer.
//
// The bench plays the PC register (pc_cur follows pc_next every clock) and
// an instruction memory with programmable response latency. A transaction
// level model (request outstanding / buffer full / drop pending) predicts
// every output each cycle; directed scenarios add literal expectations.

module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  pc_cur;
  logic [31:0]  pc_next;
  logic         imem_req_valid;
  logic [31:0]  imem_req_addr;
  logic         imem_req_ready;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         instr_valid;
  logic [31:0]  instr_data;
  logic [31:0]  instr_pc;
  logic         instr_ready;
  logic         redirect_valid;
  logic [31:0]  redirect_target;
  logic         trap_valid;
  logic         misalign_fault;
  fetch_state_e dbg_state;

  fetch_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .misalign_fault  (misalign_fault),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] req_log[$];   // addresses accepted by memory
  logic [31:0] hs_log[$];    // instr_pc of each decode handshake

  // memory model
  int          mem_lat  = 0;
  bit          pend     = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr;

  // transaction-level model
  bit          m_rst_cyc;
  bit          m_out;
  bit          m_full;
  bit          m_drop;
  bit          m_fault;
  logic [31:0] m_data;
  logic [31:0] m_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 12) | 32'h0000_0013;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rst_cyc = 1'b1;
    m_out     = 1'b0;
    m_full    = 1'b0;
    m_drop    = 1'b0;
    m_fault   = 1'b0;
  endtask

  function automatic logic [31:0] model_pc_next();
    logic [31:0] t;
    t = redirect_target;
    if (m_rst_cyc) return RV;
    if (trap_valid) return TV;
    if (redirect_valid) begin
`ifdef MISALIGN_TRAP_EN
      if (t[1:0] != 2'b00) return TV;
      return t;
`else
      return {t[31:2], 2'b00};
`endif
    end
    if (m_full && instr_ready) return pc_cur + 32'd4;
    return pc_cur;
  endfunction

  task automatic model_step();
    bit          flush;
    logic [31:0] t;
    t     = redirect_target;
    flush = trap_valid || redirect_valid;
    if (m_rst_cyc) begin
      m_rst_cyc = 1'b0;
      m_fault   = 1'b0;
    end else begin
`ifdef MISALIGN_TRAP_EN
      m_fault = redirect_valid && !trap_valid && (t[1:0] != 2'b00);
`else
      m_fault = 1'b0;
`endif
      if (m_full) begin
        if (flush || instr_ready) m_full = 1'b0;
      end else if (m_out) begin
        if (imem_rsp_valid) begin
          m_out = 1'b0;
          if (m_drop || flush) m_drop = 1'b0;
          else begin
            m_full = 1'b1;
            m_data = imem_rsp_data;
            m_pc   = pc_cur;
          end
        end else if (flush) begin
          m_drop = 1'b1;
        end
      end else if (imem_req_ready) begin
        m_out = 1'b1;
        if (flush) m_drop = 1'b1;
      end
    end
  endtask

  // Single compare point: every cycle, away from the active edge.
  task automatic compare_outputs();
    chk1 ("imem_req_valid", imem_req_valid, !m_rst_cyc && !m_out && !m_full);
    chk32("imem_req_addr",  imem_req_addr,  pc_cur);
    chk32("pc_next",        pc_next,        model_pc_next());
    chk1 ("instr_valid",    instr_valid,    m_full);
    if (m_full) begin
      chk32("instr_data", instr_data, m_data);
      chk32("instr_pc",   instr_pc,   m_pc);
    end
    chk1 ("misalign_fault", misalign_fault, m_fault);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1 with this cycle's inputs already driven.
  task automatic cycle();
    logic [31:0] nxt;
    logic [31:0] acc_addr;
    bit          acc;
    @(negedge clk);
    compare_outputs();
    nxt      = pc_next;
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    if (acc) req_log.push_back(acc_addr);
    if (instr_valid && instr_ready) hs_log.push_back(instr_pc);
    model_step();
    @(posedge clk);
    #1;
    pc_cur         = nxt;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_cnt  = mem_lat;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  // what: 0 buffer full, 1 request outstanding, 2 requesting,
  //       3 new request accepted, 4 new decode handshake
  task automatic run_until(input int what, input string tag, output int cycles);
    int n0;
    int h0;
    bit done;
    n0     = req_log.size();
    h0     = hs_log.size();
    done   = 1'b0;
    cycles = 0;
    while (!done && cycles < 40) begin
      case (what)
        0:       done = m_full;
        1:       done = m_out;
        2:       done = !m_rst_cyc && !m_out && !m_full;
        3:       done = (req_log.size() > n0);
        default: done = (hs_log.size() > h0);
      endcase
      if (!done) begin
        cycle();
        cycles++;
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL timeout_%s: got no event expected within 40 cycles", tag);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1 ({tag, "_instr_valid"}, instr_valid,    1'b0);
    chk32({tag, "_instr_data"},  instr_data,     32'h0);
    chk32({tag, "_instr_pc"},    instr_pc,       32'h0);
    chk1 ({tag, "_req_valid"},   imem_req_valid, 1'b0);
    chk1 ({tag, "_fault"},       misalign_fault, 1'b0);
    chk32({tag, "_pc_next"},     pc_next,        RV);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int          cyc;
    int          n0;
    int          h0;
    logic [31:0] held_pc;
    logic [31:0] held_data;

    pc_cur          = 32'hDEAD_BEE0;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    trap_valid      = 1'b0;

    // Reset state
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // T1: zero-wait memory, decode always ready
    run_until(0, "first_fill", cyc);
    chk32("first_fill_latency", cyc, 3);
    chk32("first_instr_data", instr_data, 32'h0000_0013);
    chk32("first_instr_pc",   instr_pc,   32'h0000_0000);
    repeat (7) cycle();
    chk32("seq_req0", req_log[0], 32'h0);
    chk32("seq_req1", req_log[1], 32'h4);
    chk32("seq_req2", req_log[2], 32'h8);
    chk32("seq_hs2",  hs_log[2],  32'h8);

    // T2: decode stall for 5 cycles in DELIVER
    instr_ready = 1'b0;
    run_until(0, "stall_fill", cyc);
    held_pc   = pc_cur;
    held_data = instr_data;
    n0        = req_log.size();
    repeat (5) cycle();
    chk32("stall_pc_hold",   pc_cur,         held_pc);
    chk32("stall_data_hold", instr_data,     held_data);
    chk32("stall_no_req",    req_log.size(), n0);
    instr_ready = 1'b1;
    cycle();
    chk32("stall_release", pc_cur, held_pc + 32'd4);

    // T3: redirect to 0x200 while waiting for a slow response
    mem_lat = 2;
    run_until(1, "redir_out", cyc);
    h0              = hs_log.size();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    cycle();
    redirect_valid = 1'b0;
    mem_lat        = 0;
    chk32("redir_pc_next", pc_cur, 32'h0000_0200);
    n0 = req_log.size();
    run_until(3, "redir_req", cyc);
    chk32("redir_req_addr", req_log[n0], 32'h0000_0200);
    chk32("redir_no_instr", hs_log.size(), h0);

    // T4: trap and redirect together while a request is not accepted
    imem_req_ready = 1'b0;
    run_until(2, "trap_req", cyc);
    trap_valid      = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0300;
    cycle();
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    chk32("trap_priority", pc_cur, TV);
    imem_req_ready = 1'b1;
    n0 = req_log.size();
    run_until(3, "trap_fetch", cyc);
    chk32("trap_req_addr", req_log[n0], TV);

    // T5: sequential advance wraps from 0xFFFF_FFFC to 0
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    h0 = hs_log.size();
    run_until(4, "wrap_hs", cyc);
    chk32("wrap_hs_pc",  hs_log[h0], 32'hFFFF_FFFC);
    chk32("wrap_pc_next", pc_cur,    32'h0000_0000);
    n0 = req_log.size();
    run_until(3, "wrap_req", cyc);
    chk32("wrap_req_addr", req_log[n0], 32'h0000_0000);

    // T6: misaligned redirect target 0x202
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0202;
    cycle();
    redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    chk1 ("misalign_pulse",   misalign_fault, 1'b1);
    chk32("misalign_pc_next", pc_cur,         TV);
`else
    chk1 ("misalign_pulse",   misalign_fault, 1'b0);
    chk32("misalign_pc_next", pc_cur,         32'h0000_0200);
`endif
    n0 = req_log.size();
    run_until(3, "misalign_req", cyc);
`ifdef MISALIGN_TRAP_EN
    chk32("misalign_req_addr", req_log[n0], TV);
`else
    chk32("misalign_req_addr", req_log[n0], 32'h0000_0200);
`endif

    // T7: asynchronous reset in the middle of RESP
    mem_lat = 3;
    run_until(2, "rst_req", cyc);
    run_until(1, "rst_out", cyc);
    cycle();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst            = 1'b1;
    pend           = 1'b0;
    imem_rsp_valid = 1'b0;
    mem_lat        = 0;
    pc_cur         = 32'hDEAD_BEE0;
    model_reset();
    n0 = req_log.size();
    run_until(3, "post_rst_req", cyc);
    chk32("post_rst_req_addr", req_log[n0], RV);

    // T8: redirect coinciding with a decode handshake
    instr_ready = 1'b0;
    run_until(0, "hs_redir_fill", cyc);
    h0              = hs_log.size();
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    cycle();
    redirect_valid = 1'b0;
    chk32("hs_redir_consumed", hs_log.size(), h0 + 1);
    chk32("hs_redir_pc_next",  pc_cur,        32'h0000_0040);
    n0 = req_log.size();
    run_until(3, "hs_redir_req", cyc);
    chk32("hs_redir_req_addr", req_log[n0], 32'h0000_0040);
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
